// File: rtl/prog_clk_divider_if.sv
// Configuration port of prog_clk_divider: one valid/ready request carrying
// target channel, period and high time.
interface prog_clk_divider_if #(
   parameter int CH_W  = 2,
   parameter int CNT_W = 28
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_high;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_period,
      output cfg_high,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_period,
      input  cfg_high,
      output cfg_ready
   );
endinterface

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: per-channel period/high time,
// glitch-free reconfiguration applied only at period boundaries.
module prog_clk_divider #(
   parameter int CLK_HZ     = 125_000_000,
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 28,
   parameter int DEF_PERIOD = 125_000_000,
   parameter int CH_W       = 2
) (
   input  logic              clk_ht,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   prog_clk_divider_if.slave cfg,
   output logic [NUM_CH-1:0] clk_di,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] busy
);

   // A degenerate DEF_PERIOD falls back to a 1 Hz period derived from CLK_HZ.
   localparam int               DEF_INT = (DEF_PERIOD >= 2) ? DEF_PERIOD : CLK_HZ;
   localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEF_INT);
   localparam logic [CNT_W-1:0] DEF_H   = CNT_W'(DEF_INT / 2);

   logic [CNT_W-1:0]  cnt  [NUM_CH];
   logic [CNT_W-1:0]  per  [NUM_CH];
   logic [CNT_W-1:0]  hi   [NUM_CH];
   logic [CNT_W-1:0]  pper [NUM_CH];
   logic [CNT_W-1:0]  phi  [NUM_CH];
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] run;
   logic [NUM_CH-1:0] wrap;
   logic              accept;
   logic [CNT_W-1:0]  cl_period;

   // Out-of-range channel indices match nothing and so stay ready.
   always_comb begin
      cfg.cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg.cfg_ch == CH_W'(i)) begin
            cfg.cfg_ready = ~pend[i];
         end
      end
   end

   always_comb begin
      wrap = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wrap[i] = (cnt[i] == per[i] - CNT_W'(1));
      end
   end

   assign accept    = cfg.cfg_valid & cfg.cfg_ready;
   assign cl_period = (cfg.cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg.cfg_period;
   assign busy      = pend;

   // The first enabled edge after a disable only starts the channel (run is
   // still 0), so the counter reads 0 there and clk_di rises one edge later.
   // An accept can only happen with pend clear, so it never collides with an
   // apply of the same channel.
   always_ff @(posedge clk_ht or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]  <= '0;
            per[i]  <= DEF_P;
            hi[i]   <= DEF_H;
            pper[i] <= DEF_P;
            phi[i]  <= DEF_H;
         end
         pend   <= '0;
         run    <= '0;
         clk_di <= '0;
         tick   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (en[i] && run[i]) begin
               clk_di[i] <= (cnt[i] < hi[i]);
               tick[i]   <= wrap[i];
               if (wrap[i]) begin
                  cnt[i] <= '0;
                  if (pend[i]) begin
                     per[i]  <= pper[i];
                     hi[i]   <= phi[i];
                     pend[i] <= 1'b0;
                  end
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else begin
               cnt[i]    <= '0;
               clk_di[i] <= 1'b0;
               tick[i]   <= 1'b0;
               if (pend[i]) begin
                  per[i]  <= pper[i];
                  hi[i]   <= phi[i];
                  pend[i] <= 1'b0;
               end
            end
            run[i] <= en[i];
            if (accept && (cfg.cfg_ch == CH_W'(i))) begin
               pper[i] <= cl_period;
               phi[i]  <= cfg.cfg_high;
               pend[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Testbench for prog_clk_divider: table-driven channel configurations plus
// hand-written sequences, with expected waveforms queued in a scoreboard.
module tb_prog_clk_divider;

   localparam int NUM_CH     = 4;
   localparam int CNT_W      = 28;
   localparam int CH_W       = 2;
   localparam int DEF_PERIOD = 10;

   logic              clk_ht = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] clk_di;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] busy;

   prog_clk_divider_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

   prog_clk_divider #(
      .CLK_HZ     (125_000_000),
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .CH_W       (CH_W)
   ) dut (
      .clk_ht (clk_ht),
      .rst_n  (rst_n),
      .en     (en),
      .cfg    (cfg_if),
      .clk_di (clk_di),
      .tick   (tick),
      .busy   (busy)
   );

   always #5 clk_ht = ~clk_ht;

   typedef struct {
      logic [3:0] clk;
      logic [3:0] tck;
      string      name;
   } exp_t;

   typedef struct {
      int    ch;
      int    period;
      int    high;
      string pat;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[7];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("[TB] FAIL %s: got %02h, expected %02h", name, act, req);
   endtask

   // One clock; outputs are sampled 1 ns after the edge and compared with the
   // oldest scoreboard entry, if any.
   task automatic step();
      exp_t e;
      @(posedge clk_ht);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_output(e.name, {clk_di, tick}, {e.clk, e.tck});
      end
   endtask

   task automatic push_pattern(input logic [3:0] chans, input string cs, input string ts,
                               input string name);
      exp_t e;
      for (int i = 0; i < cs.len(); i++) begin
         e.clk  = (cs[i] == "1") ? chans : 4'b0000;
         e.tck  = (ts[i] == "1") ? chans : 4'b0000;
         e.name = name;
         sb_q.push_back(e);
      end
   endtask

   task automatic apply_stimulus(input int ch, input int period, input int high);
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_ch     = CH_W'(ch);
      cfg_if.cfg_period = CNT_W'(period);
      cfg_if.cfg_high   = CNT_W'(high);
   endtask

   // Load a channel while it is disabled: accepted on one edge, applied on the next.
   task automatic configure_idle(input int ch, input int period, input int high);
      apply_stimulus(ch, period, high);
      check_output("ready_idle", {7'b0, cfg_if.cfg_ready}, 8'h01);
      step();
      cfg_if.cfg_valid = 1'b0;
      check_output("busy_after_accept", {4'b0, busy}, 8'(1 << ch));
      step();
      check_output("busy_after_apply", {4'b0, busy}, 8'h00);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      string cs, ts;

      tbl[0] = '{1, 4, 2, "1100"};
      tbl[1] = '{2, 1, 0, "00"};
      tbl[2] = '{3, 3, 5, "111"};
      tbl[3] = '{0, 5, 1, "10000"};
      tbl[4] = '{2, 6, 6, "111111"};
      tbl[5] = '{1, 2, 1, "10"};
      tbl[6] = '{3, 7, 3, "1110000"};

      rst_n             = 1'b0;
      en                = 4'b0001;
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_ch     = '0;
      cfg_if.cfg_period = '0;
      cfg_if.cfg_high   = '0;
      #1;
      check_output("reset_outputs", {clk_di, tick}, 8'h00);
      check_output("reset_busy", {4'b0, busy}, 8'h00);
      check_output("reset_ready", {7'b0, cfg_if.cfg_ready}, 8'h01);
      repeat (2) step();
      check_output("reset_hold", {clk_di, tick}, 8'h00);
      rst_n = 1'b1;

      // Default period 10, high 5 on ch0 after reset
      push_pattern(4'b0001, "011111000001111100000", "000000000010000000001", "default_ch0");
      repeat (21) step();

      // Table: configure each entry on an idle channel, then run two periods
      foreach (tbl[n]) begin
         en = 4'b0000;
         configure_idle(tbl[n].ch, tbl[n].period, tbl[n].high);
         en = 4'(1 << tbl[n].ch);
         cs = "0";
         ts = "0";
         repeat (2) begin
            cs = {cs, tbl[n].pat};
            for (int k = 0; k < tbl[n].pat.len(); k++) begin
               if (k == tbl[n].pat.len() - 1) ts = {ts, "1"};
               else ts = {ts, "0"};
            end
         end
         push_pattern(4'(1 << tbl[n].ch), cs, ts, $sformatf("table_%0d", n));
         repeat (cs.len()) step();
      end

      // Mid-period reconfiguration of ch1 from 4/2 to 6/3 at counter 1
      en = 4'b0000;
      configure_idle(1, 4, 2);
      en = 4'b0010;
      push_pattern(4'b0010, "01100111000", "00001000001", "midperiod_ch1");
      repeat (2) step();
      apply_stimulus(1, 6, 3);
      step();
      apply_stimulus(1, 8, 8);
      check_output("busy_pending", {4'b0, busy}, 8'h02);
      check_output("ready_blocked", {7'b0, cfg_if.cfg_ready}, 8'h00);
      step();
      cfg_if.cfg_valid = 1'b0;
      check_output("busy_still_pending", {4'b0, busy}, 8'h02);
      check_output("ready_still_blocked", {7'b0, cfg_if.cfg_ready}, 8'h00);
      step();
      check_output("busy_clear_at_wrap", {4'b0, busy}, 8'h00);
      check_output("ready_after_wrap", {7'b0, cfg_if.cfg_ready}, 8'h01);
      repeat (6) step();

      // Accept exactly on a wrap edge: new values wait one full old period
      en = 4'b0000;
      configure_idle(1, 4, 2);
      en = 4'b0010;
      push_pattern(4'b0010, "011001100111000", "000010001000001", "wrap_accept_ch1");
      repeat (4) step();
      apply_stimulus(1, 6, 3);
      step();
      cfg_if.cfg_valid = 1'b0;
      check_output("wrap_accept_busy", {4'b0, busy}, 8'h02);
      repeat (3) step();
      check_output("wrap_accept_busy_hold", {4'b0, busy}, 8'h02);
      step();
      check_output("wrap_accept_busy_clear", {4'b0, busy}, 8'h00);
      repeat (6) step();

      // en falling while pending: applied on the disabling edge
      en = 4'b0000;
      configure_idle(2, 4, 2);
      en = 4'b0100;
      push_pattern(4'b0100, "0110", "0000", "enfall_ch2");
      repeat (2) step();
      apply_stimulus(2, 3, 1);
      step();
      cfg_if.cfg_valid = 1'b0;
      check_output("enfall_busy", {4'b0, busy}, 8'h04);
      en = 4'b0000;
      step();
      check_output("enfall_busy_clear", {4'b0, busy}, 8'h00);
      en = 4'b0100;
      push_pattern(4'b0100, "0100100", "0001001", "enfall_new_ch2");
      repeat (7) step();

      // Short asynchronous reset pulse with a pending request on ch1
      en = 4'b0000;
      configure_idle(1, 6, 3);
      en = 4'b0010;
      push_pattern(4'b0010, "011", "000", "prereset_ch1");
      repeat (2) step();
      apply_stimulus(1, 4, 4);
      step();
      cfg_if.cfg_valid = 1'b0;
      check_output("prereset_busy", {4'b0, busy}, 8'h02);
      #2;
      rst_n = 1'b0;
      en    = 4'b0011;
      #1;
      check_output("async_reset_outputs", {clk_di, tick}, 8'h00);
      check_output("async_reset_busy", {4'b0, busy}, 8'h00);
      #2;
      rst_n = 1'b1;
      push_pattern(4'b0011, "011111000001111100000", "000000000010000000001", "postreset_ch01");
      repeat (21) step();

      check_output("scoreboard_drained", 8'(sb_q.size()), 8'h00);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
Multi-channel, runtime-programmable successor to the fixed 1 Hz divider. It generates NUM_CH independent divided clocks from clk_ht. Each channel has its own period and high time, plus a one-cycle end-of-period tick usable as a clock enable. New settings load through a valid/ready port and take effect only at period boundaries, so outputs never glitch. It sits between the board clock and the timing consumers: display scan, debounce, and second counters.

Parameters:
CLK_HZ, 125_000_000, input clock frequency (documentation and default derivation only)
NUM_CH, 4, number of independent channels (1..16)
CNT_W, 28, width of the period, high-time and counter fields
DEF_PERIOD, 125_000_000, reset period in clk_ht cycles for every channel (1 Hz)
CH_W, 2, channel index width; the integrator sets it to clog2(NUM_CH), minimum 1

Ports:
clk_ht, input, 1, system clock
rst_n, input, 1, asynchronous active-low reset
en, input, NUM_CH, per-channel run enable
cfg_valid, input, 1, configuration request
cfg_ready, output, 1, request can be accepted this cycle
cfg_ch, input, CH_W, target channel
cfg_period, input, CNT_W, new period in cycles
cfg_high, input, CNT_W, new high time in cycles
clk_di, output, NUM_CH, divided clock per channel (registered)
tick, output, NUM_CH, one-cycle pulse per channel at end of period (registered)
busy, output, NUM_CH, channel has a pending, not-yet-applied configuration

Behaviour:
- Reset (rst_n=0, asynchronous):
  - counters = 0
  - active period = DEF_PERIOD; active high = DEF_PERIOD/2
  - pending flags = 0
  - clk_di = 0, tick = 0, busy = 0
- Counter, per channel, enabled:
  - next = 0 if counter == period-1, else counter+1.
  - clk_di <= (counter < high)
  - tick <= (counter == period-1)
  - Both outputs lag the counter by exactly one cycle.
- Disabled channel (en=0):
  - counter is forced to 0, clk_di <= 0, tick <= 0.
  - On the first edge with en=1, the counter reads 0. clk_di goes 1 on the following edge if high > 0.
- Clamping, applied when a config is accepted:
  - period < 2 is stored as 2.
  - high == 0 gives clk_di constant 0.
  - high >= period gives clk_di constant 1.
  - tick still pulses once per period in both cases.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] (combinational on cfg_ch). cfg_ch >= NUM_CH gives cfg_ready = 1.
  - Accept = cfg_valid & cfg_ready. For an out-of-range cfg_ch the request is accepted and discarded.
  - On accept, the clamped values go into the pending registers of cfg_ch and pending is set.
  - busy = pending.
- Apply rules:
  - Enabled channel: pending values are applied on the edge where the counter wraps (counter == period-1). The counter goes to 0 and pending clears on that same edge, so the next period uses the new settings in full.
  - If the accept edge coincides with a wrap edge, the new values apply at the following wrap, not the current one.
  - Disabled channel: pending values are applied on the edge after accept.
- Simultaneous events:
  - en falling while pending: the apply occurs on the next edge.
  - Different channels are fully independent.
- Reset mid-operation: all pending requests are discarded and the defaults are restored.
- Arithmetic: unsigned CNT_W-bit throughout, with no overflow, because counter <= period-1.

Test Plan:
- Reset with en=4'b0001 → ch0 clk_di stays high for 62_500_000 cycles and low for 62_500_000 cycles; tick fires once every 125_000_000 cycles. Sim sets DEF_PERIOD=10 → pattern 1111100000.
- cfg ch1 period=4 high=2, en[1]=1 → clk_di[1] = 1100 repeating; tick[1] high on each 4th cycle aligned with the final 0.
- ch1 running period=4 → accept period=6 high=3 at counter=1 → busy[1]=1 and the old 1100 period completes. Next period is 111000; busy clears at the wrap edge. A second request while busy sees cfg_ready=0 until then.
- Accept on the exact wrap edge → the new value applies one full old period later.
- Clamps → period=1 high=0 gives period 2 with clk_di constant 0 and tick every 2 cycles; period=3 high=5 gives clk_di constant 1.
- rst_n pulse low mid-period for under one clock cycle → outputs go 0 immediately (asynchronously), busy clears, and the defaults are restored after release.
